// File: rtl/hello_pkg.sv
// hello_pkg: shared character codes and active-low g..a segment patterns
package hello_pkg;
  localparam logic [2:0] CH_H     = 3'd0;
  localparam logic [2:0] CH_E     = 3'd1;
  localparam logic [2:0] CH_L     = 3'd2;
  localparam logic [2:0] CH_O     = 3'd3;
  localparam logic [2:0] CH_BLANK = 3'd7;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/hello_char_seg.sv
// hello_char_seg: combinational 3-bit character code to active-low segments
module hello_char_seg
  import hello_pkg::*;
(
  input  logic [2:0] code,
  output logic [6:0] seg
);
  always_comb seg = code == CH_H ? SEG_H :
                    code == CH_E ? SEG_E :
                    code == CH_L ? SEG_L :
                    code == CH_O ? SEG_O : SEG_BLANK;
endmodule

// File: rtl/hello_scroller.sv
// hello_scroller: multi-digit seven-segment driver scrolling a circular message
module hello_scroller
  import hello_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 8,
  parameter int TICK_DIV   = 50000000,
  parameter int CODE_W     = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          mode,
  input  logic                          dir,
  input  logic                          load,
  input  logic [MSG_LEN*CODE_W-1:0]     msg_in,
  output logic                          step,
  output logic [$clog2(MSG_LEN)-1:0]    offset,
  output logic [NUM_DIGITS*7-1:0]       segs
);
  localparam int OW = $clog2(MSG_LEN);
  localparam int CW = $clog2(TICK_DIV);
  logic [MSG_LEN*CODE_W-1:0]    msg_q, msg_d;
  logic [OW-1:0]                off_q, off_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         step_q, step_d, tick;
  logic [NUM_DIGITS*7-1:0]      segs_q, segs_d;
  logic [NUM_DIGITS*CODE_W-1:0] codes;
  // digit i reads the buffer at (offset+i) mod MSG_LEN, so short messages repeat
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    assign codes[CODE_W*i +: CODE_W] = msg_q[CODE_W*((int'(off_q) + i) % MSG_LEN) +: CODE_W];
    hello_char_seg u_seg (
      .code(codes[CODE_W*i +: CODE_W]),
      .seg (segs_d[7*i +: 7])
    );
  end
  always_comb begin
    tick   = en && mode && cnt_q == CW'(TICK_DIV - 1);
    msg_d  = load ? msg_in : msg_q;
    cnt_d  = (load || !mode || tick) ? '0 : en ? cnt_q + CW'(1) : cnt_q;
    off_d  = load  ? '0 :
             !tick ? off_q :
             dir   ? (off_q == '0 ? OW'(MSG_LEN - 1) : off_q - OW'(1)) :
                     (off_q == OW'(MSG_LEN - 1) ? '0 : off_q + OW'(1));
    step_d = tick && !load;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_q  <= '1;
      off_q  <= '0;
      cnt_q  <= '0;
      step_q <= 1'b0;
      segs_q <= '1;
    end else begin
      msg_q  <= msg_d;
      off_q  <= off_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      segs_q <= segs_d;
    end
  end
  assign step   = step_q;
  assign offset = off_q;
  assign segs   = segs_q;
endmodule
